// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared widths, header field positions, receiver state enum
//                and a header-field helper for the router packet receiver.
//  Ports       : (package - none)
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  // No output port answers to this address, so it is always an address error.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2,
    DONE    = 2'd3
  } rx_state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_rx_fifo
//  Description : Synchronous FIFO holding payload bytes plus their last tag.
//                Pointers wrap modulo DEPTH; simultaneous push and pop keeps
//                the occupancy unchanged.
//  Ports       : clock, reset     - clock / synchronous active-high reset
//                push, push_data  - write side
//                pop, pop_data    - read side (pop_data shows the head entry)
//                empty, count     - occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  // A push into a full FIFO is only taken when the head is leaving the same cycle.
  assign w_do_push = push && ((r_count != (PTR_W+1)'(DEPTH)) || w_do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/router_pkt_rx.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_rx
//  Description : Packet receiver for one router output port. Drains the
//                router output FIFO, parses {len,addr} header, payload and
//                parity byte, forwards payload on a valid/ready stream and
//                reports per-packet status (length, parity, address,
//                truncation).
//  Optional    : RX_STATS_EN adds saturating pkt_count / err_count outputs.
//  Ports       : clock, reset                 - clock / sync active-high reset
//                valid_out, data_out, read_enb - router output FIFO interface
//                pl_data, pl_valid, pl_ready, pl_last - payload stream
//                pkt_done, pkt_len, parity_err, addr_err, trunc_err - status
//                pkt_count, err_count         - statistics (RX_STATS_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module router_pkt_rx
  import router_pkg::*;
#(
  parameter int PORT_ID   = 0,
  parameter int BUF_DEPTH = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_out,
  input  logic [DATA_W-1:0] data_out,
  output logic              read_enb,
  output logic [DATA_W-1:0] pl_data,
  output logic              pl_valid,
  input  logic              pl_ready,
  output logic              pl_last,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              parity_err,
  output logic              addr_err,
  output logic              trunc_err
`ifdef RX_STATS_EN
  ,
  output logic [15:0]       pkt_count,
  output logic [15:0]       err_count
`endif
);

  localparam int                CNT_W       = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] c_port_addr = ADDR_W'(PORT_ID);
  localparam logic [7:0]        c_idle_max  = 8'(TIMEOUT - 1);

  rx_state_t         r_state;
  rx_state_t         w_next_state;
  logic              r_inflight;
  logic              w_capture;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_n;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  w_cnt_n;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_n;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_acc_n;
  logic [7:0]        r_idle;
  logic [7:0]        w_idle_n;
  logic              w_push;
  logic              w_push_last;
  logic              w_load;
  logic              w_perr_n;
  logic              w_aerr_n;
  logic              w_terr_n;
  logic              w_addr_bad;
  logic              w_timeout;
  logic              w_buf_empty;
  logic [CNT_W-1:0]  w_buf_count;
  logic [DATA_W:0]   w_pop_word;
  logic [CNT_W:0]    w_occupancy;

  // A byte read on cycle N is on data_out at the edge ending cycle N+1.
  assign w_capture  = r_inflight;

  assign w_addr_bad = (r_addr == ADDR_INVALID) || (r_addr != c_port_addr);
  assign w_timeout  = ((r_state == PAYLOAD) || (r_state == PARITY)) &&
                      !w_capture && (r_idle == c_idle_max);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_len_n      = r_len;
    w_cnt_n      = r_cnt;
    w_addr_n     = r_addr;
    w_acc_n      = r_acc;
    w_idle_n     = r_idle;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_load       = 1'b0;
    w_perr_n     = 1'b0;
    w_aerr_n     = 1'b0;
    w_terr_n     = 1'b0;

    case (r_state)
      HDR: begin
        w_idle_n = '0;
        if (w_capture) begin
          w_len_n      = hdr_len(data_out);
          w_addr_n     = hdr_addr(data_out);
          w_acc_n      = data_out;
          w_cnt_n      = '0;
          w_next_state = (hdr_len(data_out) != '0) ? PAYLOAD : PARITY;
        end
      end

      PAYLOAD: begin
        if (w_capture) begin
          w_push   = 1'b1;
          w_acc_n  = r_acc ^ data_out;
          w_cnt_n  = r_cnt + LEN_W'(1);
          w_idle_n = '0;
          if (r_cnt == r_len - LEN_W'(1)) begin
            w_push_last  = 1'b1;
            w_next_state = PARITY;
          end
        end else if (w_timeout) begin
          w_terr_n     = 1'b1;
          w_aerr_n     = w_addr_bad;
          w_load       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_idle_n = r_idle + 8'd1;
        end
      end

      PARITY: begin
        if (w_capture) begin
          w_perr_n     = (r_acc != data_out);
          w_aerr_n     = w_addr_bad;
          w_load       = 1'b1;
          w_idle_n     = '0;
          w_next_state = DONE;
        end else if (w_timeout) begin
          w_terr_n     = 1'b1;
          w_aerr_n     = w_addr_bad;
          w_load       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_idle_n = r_idle + 8'd1;
        end
      end

      DONE: begin
        w_idle_n     = '0;
        w_next_state = HDR;
      end

      default: begin
        w_next_state = HDR;
      end
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_acc      <= '0;
      r_idle     <= '0;
      pkt_len    <= '0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
    end else begin
      r_inflight <= read_enb;
      r_len      <= w_len_n;
      r_cnt      <= w_cnt_n;
      r_addr     <= w_addr_n;
      r_acc      <= w_acc_n;
      r_idle     <= w_idle_n;
      // Status is loaded on entry to DONE so it is valid alongside pkt_done.
      if (w_load) begin
        pkt_len    <= r_len;
        parity_err <= w_perr_n;
        addr_err   <= w_aerr_n;
        trunc_err  <= w_terr_n;
      end
    end
  end

  // Reads are reserved against buffer space, counting the byte in flight.
  // No read is launched into DONE (entering or inside), so every captured
  // byte always lands in a parsing state.
  assign w_occupancy = {1'b0, w_buf_count} + (CNT_W+1)'(r_inflight);
  assign read_enb    = valid_out && !reset &&
                       (w_occupancy < (CNT_W+1)'(BUF_DEPTH)) &&
                       (r_state != DONE) && (w_next_state != DONE);

  router_rx_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data ({w_push_last, data_out}),
    .pop       (pl_valid && pl_ready),
    .pop_data  (w_pop_word),
    .empty     (w_buf_empty),
    .count     (w_buf_count)
  );

  // Head entry is masked so stale storage never shows after reset.
  assign pl_valid = !w_buf_empty;
  assign pl_data  = pl_valid ? w_pop_word[DATA_W-1:0] : '0;
  assign pl_last  = pl_valid && w_pop_word[DATA_W];
  assign pkt_done = (r_state == DONE);

`ifdef RX_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (pkt_done) begin
      if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
      if ((parity_err || addr_err || trunc_err) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
